digital_locker: RTL and testbench
=================================

// Module: digital_locker
// PURPOSE
//  Keypad-style combination lock FSM: accepts one 4-bit digit per submit pulse.
//  Compares each NUM_DIGITS-digit entry against a fixed passcode.
//  Unlocks on a match; counts down remaining attempts on a mismatch; locks out at zero.
//  Sits behind a keypad scanner/debouncer and drives lock actuator/status LEDs.
// PARAMETERS
//  NUM_DIGITS    4        digits per entry
//  PASSCODE      16'h1234 packed code, 4 bits per digit, first digit in MS nibble (1,2,3,4)
//  MAX_ATTEMPTS  3        wrong entries allowed before lockout (1..3, fits attempts_left)
//  RELOCK_CYCLES 16       auto-relock delay, used only with LOCKER_RELOCK_TIMEOUT_EN
// PORTS
//  clk            in   1  single clock, rising edge
//  reset          in   1  asynchronous, active-high
//  submit         in   1  digit strobe; each 0->1 transition enters one digit
//  digit_in       in   4  digit value sampled with submit; any 0..15 accepted, no range check
//  unlocked       out  1  registered; 1 = correct code entered
//  locked         out  1  registered; 1 = lockout, attempts exhausted
//  attempts_left  out  2  registered; wrong entries remaining
// BEHAVIOUR
//  Reset (async): state=ENTRY, digit count=0, buffer=0, unlocked=0, locked=0,
//   attempts_left=MAX_ATTEMPTS, submit_q=0.
//  Submit is rising-edge detected: accept = submit & ~submit_q.
//   Holding submit high enters only one digit.
//   digit_in is captured on the same clock edge where accept is true.
//  ENTRY: on accept, shift digit_in into the buffer and increment the count.
//   On the NUM_DIGITS-th digit, clear the count and go to CHECK.
//  CHECK (one cycle): compare buffer to PASSCODE.
//   Match: go to UNLOCKED; unlocked=1 after the next edge.
//   Mismatch: attempts_left -= 1. If the result is 0, go to LOCKED (locked=1); else go to ENTRY.
//  Latency: last digit accepted at edge N -> outputs updated at edge N+1.
//  UNLOCKED: unlocked=1; submits ignored; stays until reset (see CONFIGURATION).
//  LOCKED: locked=1, attempts_left=0; submits ignored; exit only via reset.
//  unlocked and locked are never both 1. attempts_left never wraps below 0.
//  A submit arriving in the CHECK cycle is dropped.
//  Reset mid-entry discards partial digits and restores all attempts.
//  A correct entry does not restore attempts_left; only reset does.
// CONFIGURATION
//  LOCKER_RELOCK_TIMEOUT_EN defined:
//   - A counter runs while in UNLOCKED.
//   - After RELOCK_CYCLES cycles: unlocked=0, state=ENTRY, attempts_left=MAX_ATTEMPTS.
//  Undefined: no counter is built; UNLOCKED is held until reset.
// STRUCTURE
//  Package locker_pkg holds:
//   - state enum {ENTRY, CHECK, UNLOCKED, LOCKED}
//   - DIGIT_W=4 and ATT_W=2 constants
//   - default passcode constant
//  Sub-module: submit_edge_detect (clk, reset, submit -> accept pulse).
//  The rest is one FSM plus a shift buffer, digit counter and attempts counter.
// TESTING
//  1. Reset, enter 1,2,3,4 (1-cycle submit pulses, 1 idle cycle between)
//     -> unlocked=1 one cycle after the 4th digit; locked=0; attempts_left=3.
//  2. After reset, enter 0000, then 9999, then 8888
//     -> attempts_left 3->2->1->0; locked=1 after the third entry; unlocked stays 0.
//  3. While LOCKED, enter 1,2,3,4 -> no change; then assert reset
//     -> locked=0, attempts_left=3 immediately (async).
//  4. Hold submit high 5 cycles with digit 1, then enter 2,3,4
//     -> counts as 1 digit only; no CHECK after the first 4 pulses' worth of cycles.
//  5. Enter 1,2 then reset, then enter 1,2,3,4
//     -> partial entry discarded; unlocked=1.
//  6. With LOCKER_RELOCK_TIMEOUT_EN: after unlock, wait RELOCK_CYCLES
//     -> unlocked=0, attempts_left=3, new entry accepted.

Source files
------------

// File: rtl/locker_pkg.sv
// locker_pkg: shared state encoding, widths and default passcode for digital_locker
package locker_pkg;
  typedef enum logic [1:0] {ENTRY, CHECK, UNLOCKED, LOCKED} state_t;
  localparam int DIGIT_W = 4;
  localparam int ATT_W = 2;
  localparam logic [15:0] DEFAULT_PASSCODE = 16'h1234;
endpackage

// File: rtl/submit_edge_detect.sv
// submit_edge_detect: one-cycle accept pulse on each rising edge of submit
module submit_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic submit,
  output logic accept
);
  logic submit_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) submit_q <= 1'b0;
    else submit_q <= submit;
  assign accept = submit & ~submit_q;
endmodule

// File: rtl/digital_locker.sv
// digital_locker: keypad combination lock FSM with attempt counting and lockout
// Optional auto-relock after RELOCK_CYCLES in UNLOCKED via LOCKER_RELOCK_TIMEOUT_EN.
module digital_locker
  import locker_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] PASSCODE = DEFAULT_PASSCODE,
  parameter int MAX_ATTEMPTS = 3,
  parameter int RELOCK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             submit,
  input  logic [3:0]       digit_in,
  output logic             unlocked,
  output logic             locked,
  output logic [ATT_W-1:0] attempts_left
);
  localparam int BUF_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  state_t state;
  logic [BUF_W-1:0] buffer;
  logic [CNT_W-1:0] cnt;
  logic accept;
  logic relock_done;
  submit_edge_detect u_edge (
    .clk(clk),
    .reset(reset),
    .submit(submit),
    .accept(accept)
  );
`ifdef LOCKER_RELOCK_TIMEOUT_EN
  localparam int RL_W = $clog2(RELOCK_CYCLES + 1);
  logic [RL_W-1:0] relock_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) relock_cnt <= '0;
    else relock_cnt <= (state == UNLOCKED) ? relock_cnt + 1'b1 : '0;
  assign relock_done = (state == UNLOCKED) && (relock_cnt == RL_W'(RELOCK_CYCLES - 1));
`else
  assign relock_done = RELOCK_CYCLES < 0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= ENTRY;
      buffer        <= '0;
      cnt           <= '0;
      unlocked      <= 1'b0;
      locked        <= 1'b0;
      attempts_left <= ATT_W'(MAX_ATTEMPTS);
    end else begin
      case (state)
        ENTRY:
          if (accept) begin
            buffer <= {buffer[BUF_W-DIGIT_W-1:0], digit_in};
            if (cnt == CNT_W'(NUM_DIGITS - 1)) begin
              cnt   <= '0;
              state <= CHECK;
            end else cnt <= cnt + 1'b1;
          end
        CHECK:
          if (buffer == PASSCODE) begin
            state    <= UNLOCKED;
            unlocked <= 1'b1;
          end else begin
            attempts_left <= attempts_left - 1'b1;
            // CHECK is only reachable with at least one attempt left, so no wrap
            if (attempts_left == ATT_W'(1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else state <= ENTRY;
          end
        UNLOCKED:
          if (relock_done) begin
            state         <= ENTRY;
            unlocked      <= 1'b0;
            attempts_left <= ATT_W'(MAX_ATTEMPTS);
          end
        LOCKED: ;
      endcase
    end
endmodule

// File: tb/tb_digital_locker.sv
// tb_digital_locker: directed plus randomized checks against a digit-queue reference model
module tb_digital_locker;
  localparam int PASS = 'h1234;
  localparam int MAXA = 3;
  localparam int RELOCK = 16;
  logic clk = 1'b0;
  logic reset;
  logic submit;
  logic [3:0] digit_in;
  logic unlocked;
  logic locked;
  logic [1:0] attempts_left;
  int n_checks = 0;
  int n_fail = 0;
  int m_digits[$];
  bit m_pending, m_unl, m_lck, m_prev;
  int m_att, m_unl_cycles;

  digital_locker dut (
    .clk(clk),
    .reset(reset),
    .submit(submit),
    .digit_in(digit_in),
    .unlocked(unlocked),
    .locked(locked),
    .attempts_left(attempts_left)
  );

  always #5 clk = ~clk;

  function automatic int pass_digit(input int i);
    return (PASS >> (12 - 4 * i)) & 15;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_pending = 0;
    m_unl = 0;
    m_lck = 0;
    m_prev = 0;
    m_att = MAXA;
    m_unl_cycles = 0;
  endtask

  task automatic model_edge(input bit s, input int d);
    int code;
    bit acc;
    acc = s && !m_prev;
    m_prev = s;
    if (m_pending) begin
      m_pending = 0;
      code = 0;
      foreach (m_digits[i]) code = code * 16 + m_digits[i];
      m_digits.delete();
      if (code == PASS) begin
        m_unl = 1;
        m_unl_cycles = 0;
      end else begin
        m_att--;
        if (m_att == 0) m_lck = 1;
      end
    end else if (m_unl) begin
`ifdef LOCKER_RELOCK_TIMEOUT_EN
      m_unl_cycles++;
      if (m_unl_cycles == RELOCK) begin
        m_unl = 0;
        m_att = MAXA;
      end
`endif
    end else if (!m_lck && acc) begin
      m_digits.push_back(d);
      if (m_digits.size() == 4) m_pending = 1;
    end
  endtask

  task automatic check(input string tag);
    n_checks++;
    assert (unlocked === m_unl) else begin
      n_fail++;
      $error("FAIL %s unlocked=%0b expected %0b", tag, unlocked, m_unl);
    end
    n_checks++;
    assert (locked === m_lck) else begin
      n_fail++;
      $error("FAIL %s locked=%0b expected %0b", tag, locked, m_lck);
    end
    n_checks++;
    assert (attempts_left === 2'(m_att)) else begin
      n_fail++;
      $error("FAIL %s attempts_left=%0d expected %0d", tag, attempts_left, m_att);
    end
    n_checks++;
    assert (!(unlocked === 1'b1 && locked === 1'b1)) else begin
      n_fail++;
      $error("FAIL %s both_high unlocked=%0b locked=%0b expected not both", tag, unlocked, locked);
    end
  endtask

  task automatic cycle(input bit s, input int d, input string tag);
    submit = s;
    digit_in = 4'(d);
    @(posedge clk);
    model_edge(s, d);
    @(negedge clk);
    check(tag);
  endtask

  task automatic enter(input int d, input string tag);
    cycle(1, d, tag);
    cycle(0, 0, tag);
  endtask

  task automatic enter_code(input int code, input string tag);
    for (int i = 0; i < 4; i++) enter((code >> (12 - 4 * i)) & 15, tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    submit = 1'b0;
    #1 model_reset();
    check("async_reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_bit(input logic obs, input logic exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected %0b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    submit = 1'b0;
    digit_in = 4'd0;
    model_reset();
    @(negedge clk);
    check("reset_state");
    reset = 1'b0;
    // 1: correct code
    enter_code('h1234, "t1");
    expect_bit(unlocked, 1'b1, "t1_unlocked");
    // 2: three wrong entries
    do_reset();
    enter_code('h0000, "t2a");
    enter_code('h9999, "t2b");
    enter_code('h8888, "t2c");
    expect_bit(locked, 1'b1, "t2_locked");
    // 3: locked ignores correct code, async reset clears
    enter_code('h1234, "t3");
    expect_bit(locked, 1'b1, "t3_still_locked");
    #2 reset = 1'b1;
    #1 expect_bit(locked, 1'b0, "t3_async_locked");
    expect_bit(attempts_left == 2'd3, 1'b1, "t3_async_attempts");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check("t3_after_reset");
    // 4: held submit counts once
    repeat (5) cycle(1, 1, "t4_hold");
    cycle(0, 0, "t4_hold");
    enter(2, "t4");
    enter(3, "t4");
    expect_bit(unlocked, 1'b0, "t4_not_yet");
    enter(4, "t4");
    expect_bit(unlocked, 1'b1, "t4_unlocked");
    // 5: partial entry discarded by reset
    do_reset();
    enter(1, "t5");
    enter(2, "t5");
    do_reset();
    enter_code('h1234, "t5");
    expect_bit(unlocked, 1'b1, "t5_unlocked");
`ifdef LOCKER_RELOCK_TIMEOUT_EN
    // 6: auto relock
    repeat (RELOCK - 1) cycle(0, 0, "t6_wait");
    expect_bit(unlocked, 1'b1, "t6_before_relock");
    cycle(0, 0, "t6_relock");
    expect_bit(unlocked, 1'b0, "t6_relocked");
    enter_code('h1234, "t6_reentry");
    expect_bit(unlocked, 1'b1, "t6_unlocked_again");
`endif
    // randomized entries with variable pulse widths and gaps
    for (int e = 0; e < 40; e++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      for (int i = 0; i < 4; i++) begin
        int d;
        d = ($urandom_range(0, 9) < 6) ? pass_digit(i) : int'($urandom_range(0, 15));
        repeat ($urandom_range(1, 3)) cycle(1, d, "rand_pulse");
        repeat ($urandom_range(0, 2)) cycle(0, int'($urandom_range(0, 15)), "rand_gap");
      end
      repeat ($urandom_range(0, 3)) cycle(0, 0, "rand_idle");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
